icache_burst_rd_responder: RTL and testbench



---
 rtl/icache_burst_rd_responder.sv | 135 +++++++++++++
 tb/tb_icache_burst_rd_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_burst_rd_responder.sv
// rtl/icache_burst_rd_responder.sv - instruction-cache line refill read responder backed by a preloadable word array
//
// Accepts one line read request at a time and returns the line as a BURST_LEN-beat
// burst of 32-bit words, with rsp_last on the final beat. Parameters:
//   ADDR_WIDTH  : word-address width of the backing array (depth 2^ADDR_WIDTH)
//   BURST_LEN   : beats per burst, power of two, at most 16
//   RSP_LATENCY : idle cycles between request acceptance and the first beat (0..15)
// Ports:
//   clk, rst                      : clock and synchronous active-low reset
//   from_cache_rd_req_valid/addr  : line read request (byte address, low line bits ignored)
//   to_cache_rd_req_ready         : request accepted when high together with valid
//   to_cache_rd_rsp_valid/data/last, from_cache_rd_rsp_ready : response beat handshake
//   preload_wen/addr/wdata        : backing-array write port, honoured only in IDLE
module icache_burst_rd_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int BURST_LEN   = 8,
    parameter int RSP_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  from_cache_rd_req_valid,
    input  logic [31:0]           from_cache_rd_req_addr,
    output logic                  to_cache_rd_req_ready,
    output logic                  to_cache_rd_rsp_valid,
    output logic [31:0]           to_cache_rd_rsp_data,
    output logic                  to_cache_rd_rsp_last,
    input  logic                  from_cache_rd_rsp_ready,
    input  logic                  preload_wen,
    input  logic [ADDR_WIDTH-1:0] preload_addr,
    input  logic [31:0]           preload_wdata
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]         BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BURST_LEN - 1);
    localparam logic [3:0]            LAT_LAST  = (RSP_LATENCY > 0) ? 4'(RSP_LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [BW-1:0]         beat, beat_nxt;
    logic [3:0]            lat_cnt, lat_cnt_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;
    // Cleared by reset so req_ready stays low for the cycle following any reset edge.
    logic                  active;

    logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];

    logic                  accept;
    logic                  xfer;
    logic                  is_last;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  unused_addr_bits;

    assign req_word         = from_cache_rd_req_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{from_cache_rd_req_addr[31:ADDR_WIDTH+2], from_cache_rd_req_addr[1:0]};

    // Base is line-aligned, so OR-ing the beat index never carries out of the line.
    assign rd_addr = base | ADDR_WIDTH'(beat);

    assign to_cache_rd_req_ready = active && (state == S_IDLE);
    assign to_cache_rd_rsp_valid = (state == S_BURST);
    assign is_last               = (beat == BEAT_LAST);
    assign to_cache_rd_rsp_last  = to_cache_rd_rsp_valid && is_last;
    // Combinational read: a preload committed on the accepting edge is visible to the burst.
    assign to_cache_rd_rsp_data  = to_cache_rd_rsp_valid ? mem[rd_addr] : 32'd0;

    assign accept = from_cache_rd_req_valid && to_cache_rd_req_ready;
    assign xfer   = to_cache_rd_rsp_valid && from_cache_rd_rsp_ready;

    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        lat_cnt_nxt = lat_cnt;
        base_nxt    = base;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    base_nxt    = req_word & LINE_MASK;
                    beat_nxt    = '0;
                    lat_cnt_nxt = '0;
                    state_nxt   = (RSP_LATENCY > 0) ? S_WAIT : S_BURST;
                end
            end
            S_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    lat_cnt_nxt = '0;
                    state_nxt   = S_BURST;
                end else begin
                    lat_cnt_nxt = lat_cnt + 4'd1;
                end
            end
            S_BURST: begin
                if (xfer) begin
                    if (is_last) begin
                        beat_nxt  = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        beat_nxt = beat + BW'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            beat    <= '0;
            lat_cnt <= '0;
            base    <= '0;
            active  <= 1'b0;
        end else begin
            state   <= state_nxt;
            beat    <= beat_nxt;
            lat_cnt <= lat_cnt_nxt;
            base    <= base_nxt;
            active  <= 1'b1;
        end
    end

    // Writes outside IDLE are dropped so a burst in flight is never corrupted.
    always_ff @(posedge clk) begin
        if (rst && preload_wen && (state == S_IDLE)) begin
            mem[preload_addr] <= preload_wdata;
        end
    end

endmodule

// File: tb/tb_icache_burst_rd_responder.sv
// tb/tb_icache_burst_rd_responder.sv - self-checking scoreboard bench for icache_burst_rd_responder
module tb_icache_burst_rd_responder;

    localparam int AW  = 10;
    localparam int BL  = 8;
    localparam int LAT = 2;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic          rsp_last;
    logic          rsp_ready;
    logic          preload_wen;
    logic [AW-1:0] preload_addr;
    logic [31:0]   preload_wdata;

    logic [31:0]   model [0:(1 << AW) - 1];
    logic [31:0]   sb [$];

    int checks;
    int errors;

    icache_burst_rd_responder #(
        .ADDR_WIDTH (AW),
        .BURST_LEN  (BL),
        .RSP_LATENCY(LAT)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .from_cache_rd_req_valid(req_valid),
        .from_cache_rd_req_addr (req_addr),
        .to_cache_rd_req_ready  (req_ready),
        .to_cache_rd_rsp_valid  (rsp_valid),
        .to_cache_rd_rsp_data   (rsp_data),
        .to_cache_rd_rsp_last   (rsp_last),
        .from_cache_rd_rsp_ready(rsp_ready),
        .preload_wen            (preload_wen),
        .preload_addr           (preload_addr),
        .preload_wdata          (preload_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_last} !== 3'b000 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b last=%b data=%h, want all 0",
                     req_ready, rsp_valid, rsp_last, rsp_data);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b, want ready=1 valid=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_preload();
        for (int i = 0; i < 16; i++) begin
            preload_wen   = 1'b1;
            preload_addr  = AW'(i);
            preload_wdata = 32'h1000_0000 + i;
            model[i]      = 32'h1000_0000 + i;
            @(negedge clk);
        end
        preload_wen = 1'b0;
    endtask

    // Issues one request and consumes the burst, checking every beat against the scoreboard.
    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
    // wen_at: beat count at which a preload write to word 9 is attempted (-1 none).
    // rst_at: beat count at which reset is asserted (-1 none).
    task automatic run_burst(input logic [31:0] addr, input int mode, input int wen_at,
                             input int rst_at, input bit hold_req, input bit acc_wen,
                             input bit check_lat);
        int          base;
        int          xfers;
        int          cyc;
        int          first;
        int          ridx;
        bit          prev_stall;
        bit          wen_done;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [31:0] exp;

        base = int'((addr >> 2) & 32'h0000_03F8);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b1;
        if (acc_wen) begin
            preload_wen   = 1'b1;
            preload_addr  = AW'(base);
            preload_wdata = 32'hCAFE_0000 + base;
            model[base]   = 32'hCAFE_0000 + base;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b, want 1", req_ready);
        end
        for (int i = 0; i < BL; i++) sb.push_back(model[(base + i) % (1 << AW)]);
        @(negedge clk);
        req_valid   = hold_req;
        req_addr    = 32'h0000_0100;
        preload_wen = 1'b0;

        xfers = 0; cyc = 1; first = -1; ridx = 0; prev_stall = 0; wen_done = 0;
        prev_data = '0; prev_last = 1'b0;
        while (xfers < BL && cyc < 200) begin
            preload_wen = 1'b0;
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ((ridx % 3) == 0);
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            if (rst_at >= 0 && rsp_valid && xfers == rst_at) begin
                rst = 1'b0;
                sb.delete();
                @(negedge clk);
                checks++;
                if ({req_ready, rsp_valid, rsp_last} !== 3'b000 || rsp_data !== 32'd0) begin
                    errors++;
                    $display("FAIL abort_outputs: got ready=%b valid=%b last=%b data=%h, want all 0",
                             req_ready, rsp_valid, rsp_last, rsp_data);
                end
                rst       = 1'b1;
                req_valid = 1'b0;
                rsp_ready = 1'b0;
                @(negedge clk);
                checks++;
                if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_recover: got ready=%b valid=%b, want ready=1 valid=0", req_ready, rsp_valid);
                end
                return;
            end
            if (wen_at >= 0 && !wen_done && rsp_valid && xfers == wen_at) begin
                preload_wen   = 1'b1;
                preload_addr  = AW'(9);
                preload_wdata = 32'hDEAD_BEEF;
                wen_done      = 1;
            end
            if (rsp_valid) begin
                if (first < 0) first = cyc;
                if (prev_stall) begin
                    checks++;
                    if (rsp_data !== prev_data || rsp_last !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold: got data=%h last=%b, want data=%h last=%b",
                                 rsp_data, rsp_last, prev_data, prev_last);
                    end
                end
                if (rsp_ready) begin
                    exp = (sb.size() > 0) ? sb.pop_front() : 32'hXXXX_XXXX;
                    checks++;
                    if (rsp_data !== exp || rsp_last !== (xfers == BL - 1)) begin
                        errors++;
                        $display("FAIL beat%0d: got data=%h last=%b, want data=%h last=%b",
                                 xfers, rsp_data, rsp_last, exp, (xfers == BL - 1));
                    end
                    xfers++;
                    prev_stall = 0;
                    if (xfers == BL) req_valid = 1'b0;
                end else begin
                    prev_stall = 1;
                    prev_data  = rsp_data;
                    prev_last  = rsp_last;
                end
                ridx++;
            end else begin
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_ready: got %b at cycle %0d, want 0", req_ready, cyc);
                end
            end
            @(negedge clk);
            cyc++;
        end
        preload_wen = 1'b0;
        req_valid   = 1'b0;
        rsp_ready   = 1'b0;
        checks++;
        if (xfers != BL) begin
            errors++;
            $display("FAIL burst_count: got %0d transfers, want %0d", xfers, BL);
        end
        if (check_lat) begin
            checks++;
            if (first != LAT + 1) begin
                errors++;
                $display("FAIL first_beat_latency: got %0d, want %0d", first, LAT + 1);
            end
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_burst: got ready=%b valid=%b, want ready=1 valid=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_basic();
        run_burst(32'h0000_0020, 0, -1, -1, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        run_burst(32'h0000_0020, 1, -1, -1, 0, 0, 1);
        run_burst(32'h0000_0040, 2, -1, -1, 0, 0, 1);
    endtask

    task automatic test_misaligned();
        run_burst(32'h0000_003C, 0, -1, -1, 0, 0, 1);
    endtask

    task automatic test_wrap();
        run_burst(32'h0000_1020, 0, -1, -1, 0, 0, 1);
    endtask

    task automatic test_preload_in_burst();
        run_burst(32'h0000_0020, 0, 1, -1, 0, 0, 1);
        run_burst(32'h0000_0020, 1, -1, -1, 0, 0, 0);
    endtask

    task automatic test_hold_request();
        run_burst(32'h0000_0000, 1, -1, -1, 1, 0, 1);
    endtask

    task automatic test_preload_on_accept();
        run_burst(32'h0000_0040, 0, -1, -1, 0, 1, 1);
    endtask

    task automatic test_reset_mid_burst();
        run_burst(32'h0000_0020, 0, -1, 4, 0, 0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL abort_scoreboard: got %0d pending, want 0", sb.size());
        end
        run_burst(32'h0000_0020, 0, -1, -1, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        run_burst(32'h0000_0000, 0, -1, -1, 0, 0, 1);
        run_burst(32'h0000_0020, 2, -1, -1, 0, 0, 1);
    endtask

    initial begin
        checks = 0; errors = 0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        preload_wen = 1'b0; preload_addr = '0; preload_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) model[i] = 32'd0;
        test_reset();
        test_preload();
        test_basic();
        test_backpressure();
        test_misaligned();
        test_wrap();
        test_preload_in_burst();
        test_hold_request();
        test_preload_on_accept();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
